// File: rtl/apb_i2c_pkg.sv
// Shared register map, FSM state and interrupt bit positions for the I2C APB front end.
package apb_i2c_pkg;

  localparam int unsigned ADDR_TXDATA   = 32'h00;
  localparam int unsigned ADDR_RXDATA   = 32'h04;
  localparam int unsigned ADDR_CONFIG   = 32'h08;
  localparam int unsigned ADDR_TIMEOUT  = 32'h0C;
  localparam int unsigned ADDR_STATUS   = 32'h10;
  localparam int unsigned ADDR_INT_EN   = 32'h14;
  localparam int unsigned ADDR_INT_STAT = 32'h18;

  localparam int INT_W        = 3;
  localparam int INT_TX_EMPTY = 0;
  localparam int INT_RX_AVAIL = 1;
  localparam int INT_I2C_ERR  = 2;

  typedef enum logic [1:0] {IDLE, TX_WAIT, RX_LAT, DONE} state_t;

endpackage

// File: rtl/apb_i2c_irq.sv
// Edge-detected sticky interrupt status with W1C clear, enable mask and irq reduction.
// Latency: an input edge shows in INT_STAT and irq one PCLK after it is seen.
// Backpressure: none; a set event on the same edge as a W1C clear wins.
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             tx_empty,
  input  logic             rx_empty,
  input  logic             i2c_error,
  input  logic             en_we,
  input  logic             stat_we,
  input  logic [INT_W-1:0] wdata,
  output logic [INT_W-1:0] int_en,
  output logic [INT_W-1:0] int_stat,
  output logic             irq
);

  logic             tx_empty_q, rx_empty_q, err_q;
  logic [INT_W-1:0] set_ev, clr;

  always_comb begin
    set_ev               = '0;
    set_ev[INT_TX_EMPTY] = tx_empty & ~tx_empty_q;
    set_ev[INT_RX_AVAIL] = rx_empty_q & ~rx_empty;
    set_ev[INT_I2C_ERR]  = i2c_error & ~err_q;
    clr                  = stat_we ? wdata : '0;
  end

  // Previous-value flops reset to the idle levels so reset release raises nothing.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_empty_q <= 1'b1;
      rx_empty_q <= 1'b1;
      err_q      <= 1'b0;
      int_en     <= '0;
      int_stat   <= '0;
    end else begin
      tx_empty_q <= tx_empty;
      rx_empty_q <= rx_empty;
      err_q      <= i2c_error;
      if (en_we) int_en <= wdata;
      int_stat <= (int_stat & ~clr) | set_ev;
    end
  end

  assign irq = |(int_stat & int_en);

endmodule

// File: rtl/apb_i2c_csr.sv
// APB3 CSR slave for the I2C core: register decode, TX push and RX pop with wait states.
// Latency: CSR accesses zero-wait; RXDATA completes RX_RD_LAT cycles after the pop.
// Backpressure: full TX FIFO stalls PREADY up to TX_WAIT_MAX cycles, then PSLVERR.
module apb_i2c_csr
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int CFG_W       = 14,
  parameter int TOUT_W      = 14,
  parameter int RX_RD_LAT   = 1,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              tx_wr_en,
  output logic [DATA_W-1:0] tx_wdata,
  input  logic              tx_full,
  input  logic              tx_empty,
  output logic              rx_rd_en,
  input  logic [DATA_W-1:0] rx_rdata,
  input  logic              rx_empty,
  input  logic              i2c_error,
  output logic [CFG_W-1:0]  cfg_reg,
  output logic [TOUT_W-1:0] tout_reg,
  output logic              irq
);

  localparam int CNT_MAX = (TX_WAIT_MAX > RX_RD_LAT) ? TX_WAIT_MAX : RX_RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cfg_we, tout_we, en_we, stat_we;
  logic [INT_W-1:0] int_en, int_stat;

  assign tx_wdata = PWDATA;

  always_comb begin
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = '0;
    tx_wr_en = 1'b0;
    rx_rd_en = 1'b0;
    cfg_we   = 1'b0;
    tout_we  = 1'b0;
    en_we    = 1'b0;
    stat_we  = 1'b0;
    if (PRESETn && PSELx) begin
      unique case (state)
        IDLE: if (PENABLE) begin
          PREADY = 1'b1;
          if (PADDR[1:0] != 2'b00) begin
            PSLVERR = 1'b1;
          end else if (PADDR == ADDR_W'(ADDR_TXDATA)) begin
            if (!PWRITE)     PSLVERR  = 1'b1;
            else if (tx_full) PREADY  = 1'b0;
            else             tx_wr_en = 1'b1;
          end else if (PADDR == ADDR_W'(ADDR_RXDATA)) begin
            if (PWRITE || rx_empty) PSLVERR = 1'b1;
            else begin
              PREADY   = 1'b0;
              rx_rd_en = 1'b1;
            end
          end else if (PADDR == ADDR_W'(ADDR_CONFIG)) begin
            if (PWRITE) cfg_we = 1'b1;
            else        PRDATA = DATA_W'(cfg_reg);
          end else if (PADDR == ADDR_W'(ADDR_TIMEOUT)) begin
            if (PWRITE) tout_we = 1'b1;
            else        PRDATA  = DATA_W'(tout_reg);
          end else if (PADDR == ADDR_W'(ADDR_STATUS)) begin
            if (PWRITE) PSLVERR = 1'b1;
            else        PRDATA  = DATA_W'({i2c_error, rx_empty, tx_empty, tx_full});
          end else if (PADDR == ADDR_W'(ADDR_INT_EN)) begin
            if (PWRITE) en_we  = 1'b1;
            else        PRDATA = DATA_W'(int_en);
          end else if (PADDR == ADDR_W'(ADDR_INT_STAT)) begin
            if (PWRITE) stat_we = 1'b1;
            else        PRDATA  = DATA_W'(int_stat);
          end else begin
            PSLVERR = 1'b1;
          end
        end
        TX_WAIT: begin
          if (!tx_full) begin
            PREADY   = 1'b1;
            tx_wr_en = 1'b1;
          end else if (cnt == CNT_W'(TX_WAIT_MAX)) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
          end
        end
        RX_LAT: if (cnt == CNT_W'(RX_RD_LAT)) begin
          PREADY = 1'b1;
          PRDATA = rx_rdata;
        end
        default: ;
      endcase
    end
  end

  // cnt counts stalled cycles of the current access, the first access cycle included.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      cfg_reg  <= '0;
      tout_reg <= '0;
    end else begin
      if (cfg_we)  cfg_reg  <= PWDATA[CFG_W-1:0];
      if (tout_we) tout_reg <= PWDATA[TOUT_W-1:0];
      unique case (state)
        IDLE: if (PSELx && PENABLE) begin
          cnt <= CNT_W'(1);
          if (PREADY)        state <= DONE;
          else if (rx_rd_en) state <= RX_LAT;
          else               state <= TX_WAIT;
        end
        TX_WAIT, RX_LAT: begin
          if (!PSELx)      state <= IDLE;
          else if (PREADY) state <= DONE;
          else             cnt   <= cnt + CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  apb_i2c_irq u_irq (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .tx_empty  (tx_empty),
    .rx_empty  (rx_empty),
    .i2c_error (i2c_error),
    .en_we     (en_we),
    .stat_we   (stat_we),
    .wdata     (PWDATA[INT_W-1:0]),
    .int_en    (int_en),
    .int_stat  (int_stat),
    .irq       (irq)
  );

endmodule
